// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, credit-limited imem requests,
// in-order response capture into a prefetch FIFO, and redirect flush/restart.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   fifo_pc_q   [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];

  logic          req_fire_s;
  logic          rsp_fire_s;
  logic          push_s;
  logic          pop_s;
  logic [31:0]   redir_pc_s;

  // Credit covers both buffered and in-flight words, so a push never overflows.
  assign imem_req_valid = reset & ((inflight_q + count_q) < CW'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;

  assign req_fire_s = imem_req_valid & imem_req_ready;
  assign rsp_fire_s = imem_rsp_valid & (inflight_q != {CW{1'b0}});
  assign push_s     = rsp_fire_s & (discard_q == {CW{1'b0}}) & ~redirect_valid;
  assign pop_s      = instr_valid & instr_ready;
  assign redir_pc_s = redirect_pc & 32'hFFFF_FFFC;

  assign instr_valid = (count_q != {CW{1'b0}});
  assign instr       = fifo_data_q[rd_ptr_q];
  assign instr_pc    = fifo_pc_q[rd_ptr_q];

  // Next-state for PCs, counters and FIFO pointers; redirect overrides all but the pop.
  always_comb begin
    inflight_d = inflight_q + CW'(req_fire_s) - CW'(rsp_fire_s);
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    discard_d  = discard_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (redirect_valid) begin
      fetch_pc_d = redir_pc_s;
      rsp_pc_d   = redir_pc_s;
      discard_d  = inflight_d;
      count_d    = {CW{1'b0}};
      rd_ptr_d   = {AW{1'b0}};
      wr_ptr_d   = {AW{1'b0}};
    end else begin
      fetch_pc_d = req_fire_s ? (fetch_pc_q + 32'd4) : fetch_pc_q;
      if (rsp_fire_s && (discard_q != {CW{1'b0}})) begin
        discard_d = discard_q - {{(CW-1){1'b0}}, 1'b1};
      end else begin
        discard_d = discard_q;
      end
      rsp_pc_d = push_s ? (rsp_pc_q + 32'd4) : rsp_pc_q;
      wr_ptr_d = push_s ? (wr_ptr_q + {{(AW-1){1'b0}}, 1'b1}) : wr_ptr_q;
      rd_ptr_d = pop_s  ? (rd_ptr_q + {{(AW-1){1'b0}}, 1'b1}) : rd_ptr_q;
      count_d  = count_q + CW'(push_s) - CW'(pop_s);
    end
  end

  // Control state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= {CW{1'b0}};
      discard_q  <= {CW{1'b0}};
      count_q    <= {CW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      wr_ptr_q   <= {AW{1'b0}};
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // FIFO storage; flushed entries are simply orphaned by the pointer reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc_q[i]   <= 32'h0000_0000;
        fifo_data_q[i] <= 32'h0000_0000;
      end
    end else if (push_s) begin
      fifo_pc_q[wr_ptr_q]   <= rsp_pc_q;
      fifo_data_q[wr_ptr_q] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit: an in-order memory model plus an
// architectural model of the expected request and instruction PC streams.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready    = 1'b0;

  fetch_unit #(.RESET_PC(RPC), .DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Stimulus knobs (percentages and latency range)
  int p_req = 100, p_instr = 100, p_rsp = 100, p_redir = 0;
  int lat_min = 1, lat_max = 1;
  bit force_redir = 1'b0;
  logic [31:0] force_pc = 32'h0;

  // Reference model
  int          cyc = 0;
  logic [31:0] exp_req, exp_out;
  logic [31:0] addrq[$];
  int          dueq[$];
  bit          hold_pending = 1'b0;
  logic [31:0] hold_addr;

  // Per-step observations
  bit s_fire, s_pop, s_rsp;
  logic [31:0] s_addr, s_pc;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    addrq.delete(); dueq.delete(); hold_pending = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, RPC);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    exp_req = RPC; exp_out = RPC;
    #1;
    chk("rel_req_valid", 32'(imem_req_valid), 32'd1);
    chk("rel_req_addr", imem_req_addr, RPC);
  endtask

  task automatic step();
    logic        do_redir;
    logic [31:0] rpc;
    @(negedge clock);
    imem_req_ready = ($urandom_range(99) < p_req);
    instr_ready    = ($urandom_range(99) < p_instr);
    do_redir = force_redir || ($urandom_range(99) < p_redir);
    rpc = force_redir ? force_pc : $urandom;
    force_redir = 1'b0;
    redirect_valid = do_redir;
    redirect_pc    = rpc;
    if (addrq.size() > 0 && dueq[0] <= cyc && $urandom_range(99) < p_rsp) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memword(addrq[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    s_fire = imem_req_valid && imem_req_ready;
    s_addr = imem_req_addr;
    s_pop  = instr_valid && instr_ready;
    s_pc   = instr_pc;
    s_rsp  = imem_rsp_valid;
    if (hold_pending) chk("addr_hold", imem_req_addr, hold_addr);
    hold_pending = imem_req_valid && !imem_req_ready && !do_redir;
    hold_addr    = imem_req_addr;
    if (s_pop) begin
      chk("out_pc", instr_pc, exp_out);
      chk("out_instr", instr, memword(exp_out));
      exp_out += 32'd4;
    end
    if (s_fire) begin
      chk("req_addr", imem_req_addr, exp_req);
      exp_req += 32'd4;
      addrq.push_back(imem_req_addr);
      dueq.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
    end
    if (s_rsp) begin
      void'(addrq.pop_front());
      void'(dueq.pop_front());
    end
    if (do_redir) begin
      exp_req = rpc & 32'hFFFF_FFFC;
      exp_out = rpc & 32'hFFFF_FFFC;
    end
    @(posedge clock);
    cyc++;
    #1;
    if (do_redir) begin
      chk("redir_flush", 32'(instr_valid), 32'd0);
      chk("redir_addr", imem_req_addr, exp_req);
    end
  endtask

  initial begin
    int n, first_acc, first_pop;
    bit got_acc, got_pop;
    logic [31:0] acc_addr, pop_pc;
    #2;
    do_reset();

    // Streaming, L=1, all ready
    first_acc = -1; first_pop = -1; n = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (s_fire && first_acc < 0) first_acc = cyc - 1;
      if (s_pop && first_pop < 0) first_pop = cyc - 1;
      if (i >= 5 && s_pop) n++;
    end
    chk("first_out_latency", 32'(first_pop - first_acc), 32'd2);
    chk("throughput", 32'(n), 32'd20);

    // Consumer stalled: credit limit
    do_reset();
    p_instr = 0; n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (s_fire) n++;
    end
    chk("credit_accepts", 32'(n), 32'd4);
    chk("credit_req_valid", 32'(imem_req_valid), 32'd0);
    p_instr = 100; got_acc = 1'b0; acc_addr = 32'h0;
    for (int i = 0; i < 20 && !got_acc; i++) begin
      step();
      if (s_fire) begin got_acc = 1'b1; acc_addr = s_addr; end
    end
    chk("resume_addr", acc_addr, 32'h0000_0110);
    for (int i = 0; i < 6; i++) step();

    // Memory not ready for 5 cycles mid-stream
    p_req = 0;
    for (int i = 0; i < 5; i++) step();
    p_req = 100;
    for (int i = 0; i < 10; i++) step();

    // L=3 with 3 in flight, redirect to 0x2003
    lat_min = 3; lat_max = 3; got_acc = 1'b0;
    for (int i = 0; i < 30 && !got_acc; i++) begin
      step();
      if (addrq.size() == 3) got_acc = 1'b1;
    end
    chk("inflight3_reached", 32'(got_acc), 32'd1);
    force_redir = 1'b1; force_pc = 32'h0000_2003;
    step();
    got_acc = 1'b0; got_pop = 1'b0; acc_addr = 32'h0; pop_pc = 32'h0;
    for (int i = 0; i < 40 && !(got_acc && got_pop); i++) begin
      step();
      if (s_fire && !got_acc) begin got_acc = 1'b1; acc_addr = s_addr; end
      if (s_pop && !got_pop) begin got_pop = 1'b1; pop_pc = s_pc; end
    end
    chk("redir_first_req", acc_addr, 32'h0000_2000);
    chk("redir_first_out", pop_pc, 32'h0000_2000);

    // Redirect coinciding with consume, response and request acceptance
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 8; i++) step();
    force_redir = 1'b1; force_pc = 32'h0000_3000;
    step();
    chk("triple_event", {29'd0, s_pop, s_rsp, s_fire}, 32'd7);
    got_pop = 1'b0; pop_pc = 32'h0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (s_pop && !got_pop) begin got_pop = 1'b1; pop_pc = s_pc; end
    end
    chk("triple_first_out", pop_pc, 32'h0000_3000);

    // Randomized traffic with random redirects
    lat_min = 1; lat_max = 4; p_req = 70; p_instr = 70; p_rsp = 80; p_redir = 3;
    for (int i = 0; i < 3000; i++) step();

    // Asynchronous reset between edges mid-stream
    p_redir = 0;
    for (int i = 0; i < 5; i++) step();
    #2;
    do_reset();
    p_req = 100; p_instr = 100; p_rsp = 100; lat_min = 1; lat_max = 1;
    got_acc = 1'b0; acc_addr = 32'h0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (s_fire && !got_acc) begin got_acc = 1'b1; acc_addr = s_addr; end
    end
    chk("post_reset_first_req", acc_addr, RPC);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
